// File: rtl/softmax_pkg.sv
// Shared types and constants for softmax_stream: FSM state encoding and the
// 64-entry 2^(-d/4) exponent table.
package softmax_pkg;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_EXP  = 2'd1,
    S_DIV  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam int EXP_W = 16;

  // floor(65535 * 2^(-d/4)): floor((65535 * 2^(-r/4)) >> q) with d = 4q + r
  // is exact, so only the four fractional bases need storing.
  function automatic logic [EXP_W-1:0] exp_lut(input logic [5:0] d);
    logic [EXP_W-1:0] base;
    case (d[1:0])
      2'd0:    base = EXP_W'(65535);
      2'd1:    base = EXP_W'(55108);
      2'd2:    base = EXP_W'(46340);
      default: base = EXP_W'(38967);
    endcase
    return base >> d[5:2];
  endfunction

endpackage

// File: rtl/softmax_div.sv
// Sequential restoring divider producing floor((dividend << OUT_W) / divisor),
// one quotient bit per cycle, saturated to OUT_W bits.
module softmax_div #(
  parameter int DIVD_W = 16,
  parameter int DIVS_W = 18,
  parameter int OUT_W  = 16
) (
  input  logic              aclk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [DIVD_W-1:0] i_dividend,
  input  logic [DIVS_W-1:0] i_divisor,
  output logic              o_busy,
  output logic              o_done,
  output logic [OUT_W-1:0]  o_quot
);

  localparam int CNT_W = $clog2(OUT_W + 1);

  logic [DIVS_W:0]    r_rem;
  logic [OUT_W:0]     r_quo;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               w_ge;
  logic [DIVS_W:0]    w_rem_sub;
  logic [OUT_W:0]     w_quo_nxt;

  // The caller guarantees dividend <= divisor (and a stable divisor while
  // busy), so the quotient fits in OUT_W+1 bits and the first step needs no
  // shift.
  assign w_ge      = r_rem >= {1'b0, i_divisor};
  assign w_rem_sub = w_ge ? (r_rem - {1'b0, i_divisor}) : r_rem;
  assign w_quo_nxt = {r_quo[OUT_W-1:0], w_ge};

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == '0);
  assign o_quot = w_quo_nxt[OUT_W] ? '1 : w_quo_nxt[OUT_W-1:0];

  always_ff @(posedge aclk) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= (DIVS_W + 1)'(i_dividend);
      r_quo  <= '0;
      r_cnt  <= CNT_W'(OUT_W);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem <= {w_rem_sub[DIVS_W-1:0], 1'b0};
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == '0) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/softmax_stream.sv
// Streaming softmax with argmax. Define SOFTMAX_STREAM_PROB_EN to build the
// exp/divide probability path; without it only max_ID is produced.
//   state | meaning
//   LOAD  | accept NUM_CLASS elements, track running max/argmax
//   EXP   | one element per cycle: e = 2^(-(max-x)/4), accumulate sum
//   DIV   | divide current e by sum
//   OUT   | present probability until downstream accepts
module softmax_stream
  import softmax_pkg::*;
#(
  parameter int   DATA_W    = 8,
  parameter int   NUM_CLASS = 10,
  parameter int   OUT_W     = 16,
  localparam int  ID_W      = $clog2(NUM_CLASS)
) (
  input  logic                     aclk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] s_axis_softmax_tdata,
  input  logic                     s_axis_softmax_tvalid,
  output logic                     s_axis_softmax_tready,
  output logic [OUT_W-1:0]         m_axis_dout_tdata,
  output logic                     m_axis_dout_tvalid,
  input  logic                     m_axis_dout_tready,
  output logic                     m_axis_dout_tlast,
  output logic [ID_W-1:0]          max_ID,
  output logic                     max_ID_valid
);

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_CLASS - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [ID_W-1:0]           r_cnt;
  logic signed [DATA_W-1:0]  r_max;
  logic [ID_W-1:0]           r_arg;
  logic signed [DATA_W-1:0]  w_max_nxt;
  logic [ID_W-1:0]           w_arg_nxt;
  logic [ID_W-1:0]           r_max_id;
  logic                      r_max_id_vld;
  logic                      r_tready;
  logic                      w_in_hs;
  logic                      w_out_hs;
  logic                      w_exp_step;
  logic                      w_last_cnt;

  assign w_in_hs    = s_axis_softmax_tvalid && r_tready;
  assign w_out_hs   = (r_state == S_OUT) && m_axis_dout_tready;
  assign w_last_cnt = (r_cnt == LAST_IDX);

  assign s_axis_softmax_tready = r_tready;
  assign max_ID                = r_max_id;
  assign max_ID_valid          = r_max_id_vld;

  // First element seeds the max; strict compare keeps the lowest index on ties.
  always_comb begin
    w_max_nxt = r_max;
    w_arg_nxt = r_arg;
    if ((r_cnt == '0) || (s_axis_softmax_tdata > r_max)) begin
      w_max_nxt = s_axis_softmax_tdata;
      w_arg_nxt = r_cnt;
    end
  end

`ifdef SOFTMAX_STREAM_PROB_EN
  localparam int SUM_W = EXP_W + ID_W;
  localparam int BUF_W = (DATA_W > EXP_W) ? DATA_W : EXP_W;

  logic [BUF_W-1:0]          r_buf [NUM_CLASS];
  logic signed [DATA_W-1:0]  w_x;
  logic [DATA_W:0]           w_d;
  logic [EXP_W-1:0]          w_e;
  logic [SUM_W-1:0]          r_acc;
  logic [ID_W-1:0]           w_div_idx;
  logic                      w_div_start;
  logic                      w_div_busy;
  logic                      w_div_done;
  logic [OUT_W-1:0]          w_div_quot;
  logic [OUT_W-1:0]          r_tdata;
  logic                      r_tlast;

  assign w_x = r_buf[r_cnt][DATA_W-1:0];
  assign w_d = {r_max[DATA_W-1], r_max} - {w_x[DATA_W-1], w_x};
  assign w_e = (w_d[DATA_W:6] == '0) ? exp_lut(w_d[5:0]) : '0;

  // Element 0 is fetched while EXP finishes; later ones on each output handshake.
  assign w_div_idx = (r_state == S_EXP) ? '0 : (r_cnt + ID_W'(1));

  softmax_div #(
    .DIVD_W (EXP_W),
    .DIVS_W (SUM_W),
    .OUT_W  (OUT_W)
  ) u_div (
    .aclk       (aclk),
    .rst_n      (rst_n),
    .i_start    (w_div_start),
    .i_dividend (r_buf[w_div_idx][EXP_W-1:0]),
    .i_divisor  (r_acc),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quot     (w_div_quot)
  );

  assign m_axis_dout_tvalid = (r_state == S_OUT);
  assign m_axis_dout_tdata  = r_tdata;
  assign m_axis_dout_tlast  = r_tlast;

  always_ff @(posedge aclk) begin
    if (w_in_hs) begin
      r_buf[r_cnt] <= BUF_W'(s_axis_softmax_tdata);
    end else if (r_state == S_EXP) begin
      r_buf[r_cnt] <= BUF_W'(w_e);
    end
  end

  always_ff @(posedge aclk) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_tdata <= '0;
      r_tlast <= 1'b0;
    end else begin
      if (w_in_hs && w_last_cnt) begin
        r_acc <= '0;
      end else if (w_exp_step) begin
        r_acc <= r_acc + SUM_W'(w_e);
      end
      if ((r_state == S_DIV) && w_div_done) begin
        r_tdata <= w_div_quot;
        r_tlast <= w_last_cnt;
      end
    end
  end
`else
  assign m_axis_dout_tvalid = 1'b0;
  assign m_axis_dout_tdata  = '0;
  assign m_axis_dout_tlast  = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_exp_step  = 1'b0;
`ifdef SOFTMAX_STREAM_PROB_EN
    w_div_start = 1'b0;
`endif
    case (r_state)
      S_LOAD: if (w_in_hs && w_last_cnt) w_state_nxt = S_EXP;
`ifdef SOFTMAX_STREAM_PROB_EN
      S_EXP: begin
        w_exp_step = 1'b1;
        if (w_last_cnt) begin
          w_state_nxt = S_DIV;
          w_div_start = !w_div_busy;
        end
      end
      S_DIV: if (w_div_done) w_state_nxt = S_OUT;
      S_OUT: begin
        if (w_out_hs) begin
          if (w_last_cnt) begin
            w_state_nxt = S_LOAD;
          end else begin
            w_state_nxt = S_DIV;
            w_div_start = !w_div_busy;
          end
        end
      end
`else
      S_EXP, S_DIV, S_OUT: w_state_nxt = S_LOAD;
`endif
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!rst_n) begin
      r_state      <= S_LOAD;
      r_cnt        <= '0;
      r_max        <= '0;
      r_arg        <= '0;
      r_max_id     <= '0;
      r_max_id_vld <= 1'b0;
      r_tready     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tready <= (w_state_nxt == S_LOAD);
      if (w_in_hs || w_exp_step || w_out_hs) begin
        r_cnt <= w_last_cnt ? '0 : (r_cnt + ID_W'(1));
      end
      if (w_in_hs) begin
        r_max <= w_max_nxt;
        r_arg <= w_arg_nxt;
        if (w_last_cnt) begin
          r_max_id     <= w_arg_nxt;
          r_max_id_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/softmax_stream.md
SOFTMAX_STREAM -- requirements
Module: softmax_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8: signed input element width.
REQ-002 SHALL have parameter NUM_CLASS, default 10 (range 2..256): elements per vector.
REQ-003 SHALL have parameter OUT_W, default 16: unsigned probability width, Q0.OUT_W.
REQ-004 SHALL have localparams ID_W=$clog2(NUM_CLASS), EXP_W=16, SUM_W=EXP_W+ID_W.
REQ-005 aclk  in  1  clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 s_axis_softmax_tdata  in  DATA_W  signed element, index order 0..NUM_CLASS-1.
REQ-008 s_axis_softmax_tvalid  in  1  element valid.
REQ-009 s_axis_softmax_tready  out  1  element accepted when tvalid&tready.
REQ-010 m_axis_dout_tdata  out  OUT_W  probability of current output element.
REQ-011 m_axis_dout_tvalid  out  1  output valid.
REQ-012 m_axis_dout_tready  in  1  downstream ready.
REQ-013 m_axis_dout_tlast  out  1  high with element NUM_CLASS-1.
REQ-014 max_ID  out  ID_W  index of maximum element of last completed vector.
REQ-015 max_ID_valid  out  1  max_ID valid.

Function
REQ-016 FSM states LOAD, EXP, DIV, OUT; reset state LOAD.
REQ-017 LOAD: tready=1; each handshake stores element to internal buffer[cnt], cnt++; running max/argmax updated on strict greater (ties keep lowest index); after element NUM_CLASS-1 -> EXP.
REQ-018 On LOAD->EXP: max_ID, max_ID_valid=1 registered; max_ID holds until next vector's LOAD completes.
REQ-019 EXP: one element per cycle, d=max-x (DATA_W+1 bits unsigned); e=floor(65535*2^(-d/4)) for d<64, else 0; e written back to buffer, summed into SUM_W accumulator; exactly NUM_CLASS cycles, then DIV.
REQ-020 DIV: sequential restoring divide q=floor((e<<OUT_W)/sum), saturated to 2^OUT_W-1; OUT_W+1 cycles per element; then OUT.
REQ-021 OUT: tvalid=1, tdata/tlast stable until tready; on handshake, next element -> DIV, or after last -> LOAD.
REQ-022 tready=0 in EXP, DIV, OUT; input tvalid ignored there.
REQ-023 sum is never zero (max element gives e=65535); no divide-by-zero path.
REQ-024 m_axis_dout_tvalid never high in LOAD/EXP/DIV.

Reset
REQ-025 rst_n=0 at any edge, any state: state=LOAD, cnt=0, accumulator=0, tvalid=0, tlast=0, tdata=0, max_ID=0, max_ID_valid=0; partial vector discarded.
REQ-026 tready SHALL be 0 during reset cycles, 1 on first cycle after release.

Configuration
REQ-027 Macro SOFTMAX_STREAM_PROB_EN: defined -> full EXP/DIV/OUT path as above.
REQ-028 Undefined -> argmax only: LOAD completes, max_ID/max_ID_valid update, FSM returns to LOAD next cycle; m_axis_dout_tvalid/tdata/tlast tied 0; no LUT, buffer, or divider.

Structure
REQ-029 Package softmax_pkg SHALL hold state enum, EXP_W, exp LUT constant function (64 entries).
REQ-030 Sub-module softmax_div: sequential unsigned divider, start/busy/done handshake.

Verification (NUM_CLASS=4, DATA_W=8, OUT_W=16, macro defined unless stated)
REQ-031 [0,0,0,0] -> outputs 16384 x4, tlast on 4th, max_ID=0.
REQ-032 [5,5,-128,-128] -> 32768,32768,0,0; max_ID=0 (tie to lowest).
REQ-033 [-128,-128,-128,127] -> 0,0,0,65535 (saturated); max_ID=3.
REQ-034 m_axis_dout_tready low 5 cycles on element 1 -> tdata/tvalid held stable, no loss.
REQ-035 rst_n low 1 cycle after 2 elements loaded, then [0,0,0,0] -> only second vector's 4 outputs, each 16384.
REQ-036 Macro undefined, [1,9,3,9] -> max_ID=1, max_ID_valid=1, m_axis_dout_tvalid stays 0.
